// File: rtl/dds_arb_pkg.sv
// Shared types and helpers for the DDS update arbiter.
package dds_arb_pkg;

   // Scheduler states: IDLE may grant, HOLD enforces spacing between grants
   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   // Width of the inter-grant holdoff counter (HOLDOFF is at most 15)
   localparam int unsigned HOLD_CNT_W = 4;

   // Next index in round-robin order, wrapping at n
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/dds_req_fifo.sv
// Per-requester synchronous FIFO holding matched RTO words until granted.
module dds_req_fifo #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   // Storage array; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy tracking; flush empties the FIFO
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dds_update_arbiter.sv
// Round-robin arbiter sharing one DDS parameter-update path between RTO cores.
module dds_update_arbiter
   import dds_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned HOLDOFF    = 3,
   parameter int unsigned SRC_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          flush,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_full,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [SRC_W-1:0]              out_src,
   output logic                          busy,
   output logic [NUM_REQ-1:0]            overflow_error,
   input  logic                          clear_error
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_INIT =
      (HOLDOFF > 0) ? HOLD_CNT_W'(HOLDOFF - 1) : '0;

   arb_state_t              state;
   logic [HOLD_CNT_W-1:0]   hold_cnt;
   logic [SRC_W-1:0]        rr_ptr;

   logic [NUM_REQ-1:0]      fifo_push;
   logic [NUM_REQ-1:0]      fifo_pop;
   logic [NUM_REQ-1:0]      fifo_full;
   logic [NUM_REQ-1:0]      fifo_empty;
   logic [NUM_REQ-1:0]      ovf_event;
   logic [DATA_WIDTH-1:0]   heads [NUM_REQ];

   logic                    grant_found;
   logic [SRC_W-1:0]        grant_idx;
   logic [SRC_W-1:0]        cand;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
      dds_req_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .resetn  (resetn),
         .flush   (flush),
         .push    (fifo_push[g]),
         .pop     (fifo_pop[g]),
         .wr_data (req_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .rd_data (heads[g]),
         .full    (fifo_full[g]),
         .empty   (fifo_empty[g])
      );
   end

   // Round-robin search for the first non-empty port starting at rr_ptr
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = rr_ptr;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && !fifo_empty[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
         cand = SRC_W'(rr_next(32'(cand), NUM_REQ));
      end
   end

   // Push/pop strobes and drop detection; flush masks both directions
   always_comb begin
      fifo_push = '0;
      fifo_pop  = '0;
      ovf_event = '0;
      if (!flush) begin
         fifo_push = req_valid;
         if (state == ARB_IDLE && grant_found) begin
            fifo_pop = NUM_REQ'(1) << grant_idx;
         end
         ovf_event = fifo_push & fifo_full & ~fifo_pop;
      end
   end

   // Scheduler FSM with registered grant outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ARB_IDLE;
         hold_cnt  <= '0;
         rr_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (flush) begin
         state     <= ARB_IDLE;
         hold_cnt  <= '0;
         rr_ptr    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            ARB_IDLE: begin
               if (grant_found) begin
                  out_valid <= 1'b1;
                  out_data  <= heads[grant_idx];
                  out_src   <= grant_idx;
                  rr_ptr    <= SRC_W'(rr_next(32'(grant_idx), NUM_REQ));
                  if (HOLDOFF > 0) begin
                     state    <= ARB_HOLD;
                     hold_cnt <= HOLD_INIT;
                  end
               end
            end
            ARB_HOLD: begin
               if (hold_cnt == '0) begin
                  state <= ARB_IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Sticky drop flags; a drop in the clear cycle keeps its flag set
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflow_error <= '0;
      end else begin
         overflow_error <= (clear_error ? '0 : overflow_error) | ovf_event;
      end
   end

   assign req_full = fifo_full;
   assign busy     = (~&fifo_empty) || (state != ARB_IDLE);

endmodule

// File: doc/dds_update_arbiter.md
# dds_update_arbiter

Shares one DDS parameter-update path (the `gpo_in` / `counter_matched` input of the DDS controller) between several RTO-core requesters. Each requester's matched-timestamp strobe and 128-bit word are captured into a small per-port FIFO. A round-robin scheduler forwards the words one at a time, with a programmable minimum spacing so the DDS can absorb each `sync_en` update. It sits in the RTIO clock domain, between N `RTO_Core` instances and a single `DDS_Controller`.

## Interface
- `NUM_REQ`, 4: number of requester ports (2..8).
- `DATA_WIDTH`, 128: width of the RTO output word.
- `FIFO_DEPTH`, 2: entries per port FIFO (power of two, ≥2).
- `HOLDOFF`, 3: idle cycles forced between consecutive grants (0..15).
- `SRC_W`, $clog2(NUM_REQ): width of the source index.

Ports:
- `clk`  in  1  RTIO clock; every register is clocked on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous flush, active high.
- `req_valid`  in  NUM_REQ  per-port strobe (the RTO `counter_matched`), one-cycle pulses.
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-port word; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_full`  out  NUM_REQ  port FIFO full.
- `out_valid`  out  1  one-cycle update strobe to the DDS controller.
- `out_data`  out  DATA_WIDTH  granted word; held until the next grant.
- `out_src`  out  SRC_W  index of the granted port; held with `out_data`.
- `busy`  out  1  high whenever any FIFO is non-empty or the state is not IDLE.
- `overflow_error`  out  NUM_REQ  sticky flag: a word was dropped on a full FIFO.
- `clear_error`  in  1  synchronous clear of `overflow_error`.

## Operation
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0, `busy`=0, `req_full`=0, `overflow_error`=0.
  - FIFOs empty, state IDLE, round-robin pointer `rr_ptr`=0, holdoff counter=0.
- Capture: a port with `req_valid`=1 pushes `req_data` slice i.
  - If the FIFO is full and not being popped in the same cycle, the word is dropped and `overflow_error[i]` is set.
  - A push and a pop in the same cycle on a full FIFO is accepted; no error is raised.
- Scheduler FSM:
  - IDLE: if any FIFO is non-empty, select the first non-empty port searching `rr_ptr`, `rr_ptr`+1, … mod NUM_REQ. Then:
    - pop that FIFO;
    - register its head into `out_data` and its index into `out_src`;
    - pulse `out_valid`;
    - set `rr_ptr` = granted+1 mod NUM_REQ.
    - Go to HOLD if HOLDOFF>0; otherwise stay in IDLE (back-to-back grants allowed).
  - HOLD: the counter loads HOLDOFF−1 on entry and decrements each cycle. Return to IDLE when it reaches 0. No grants are made in HOLD.
- `flush`:
  - empties all FIFOs, forces IDLE, sets `rr_ptr`=0, drives `out_valid`=0;
  - `req_valid` in the flush cycle is ignored;
  - `out_data`/`out_src` keep their values; `overflow_error` is not cleared.
- `clear_error`: clears the flags in that cycle. A simultaneous overflow wins, so the flag stays 1.
- `resetn` asserted mid-operation discards all state immediately; no pending `out_valid` survives.

## Timing
- Latency: `req_valid` at cycle t into an empty FIFO, with the FSM in IDLE, gives `out_valid` high in cycle t+2.
- Sustained spacing: consecutive `out_valid` pulses are exactly HOLDOFF+1 cycles apart while any FIFO is non-empty.
- `out_valid` is never high in two consecutive cycles when HOLDOFF>0.
- `req_full` is registered and reflects the FIFO occupancy after the current cycle's push/pop.
- `busy` is combinational from the registered state only; it must not depend on `req_valid`.

## Structure
- Package `dds_arb_pkg`: FSM state enum (`ARB_IDLE`, `ARB_HOLD`), a round-robin next-index function, and the HOLDOFF counter width constant (4).
- One sub-module, `dds_req_fifo`:
  - synchronous FIFO with `DATA_WIDTH`/`FIFO_DEPTH` parameters and push/pop/full/empty ports;
  - instantiated NUM_REQ times in a generate loop.
- The arbiter logic and the error flags stay in the top module.

## Test plan
- Reset with `resetn` low mid-stream: all outputs read 0 while low. After release, a pulse on port 2 with data 128'hA5 gives `out_valid` two cycles later, with `out_src`=2 and `out_data`=128'hA5.
- Simultaneous `req_valid`=4'b1111 with HOLDOFF=3: grants follow port order 0,1,2,3, with `out_valid` pulses exactly 4 cycles apart. `busy` drops the cycle after the final HOLD ends.
- Round-robin fairness: keep ports 0 and 3 continuously refilled. Grants alternate 0,3,0,3; port 0 is never granted twice in a row.
- Overflow: three pulses on port 1 within 3 cycles, with FIFO_DEPTH=2, while HOLD blocks grants. Third word dropped, `overflow_error[1]`=1, and only the first two words appear on `out_data`. `clear_error` then returns the flag to 0.
- Push and pop on a full FIFO in the same cycle: the word is accepted, and `overflow_error` stays 0.
- `flush` with two ports holding words: no `out_valid` afterwards, `busy`=0 next cycle, next grant starts the search from port 0, and `overflow_error` is unchanged.
